// File: rtl/aes_shift_rows_pipe_if.sv
// Valid/ready stream bundle for the ShiftRows pipeline stage.
// The slave modport is the stage itself; master is the producer/consumer around it.
interface aes_shift_rows_pipe_if #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_dec;
    logic [0:32*NB-1]     in_state;
    logic [TAG_W-1:0]     in_tag;

    logic                 out_valid;
    logic                 out_ready;
    logic [0:32*NB-1]     out_state;
    logic [TAG_W-1:0]     out_tag;

    modport slave (
        input  in_valid, in_dec, in_state, in_tag, out_ready,
        output in_ready, out_valid, out_state, out_tag
    );

    modport master (
        output in_valid, in_dec, in_state, in_tag, out_ready,
        input  in_ready, out_valid, out_state, out_tag
    );
endinterface

// File: rtl/aes_shift_rows_pipe.sv
// Rijndael ShiftRows / InvShiftRows stage for Nb = 4, 6 or 8 columns.
// The permuted state is registered behind a 2-entry skid buffer so the output side is register-only.
module aes_shift_rows_pipe #(
    parameter int NB    = 4,
    parameter int MODE  = 2,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    aes_shift_rows_pipe_if.slave bus,
    output logic [1:0]           occupancy
);
    localparam int W = 32 * NB;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (MODE < 0 || MODE > 2) begin : g_bad_mode
        $error("aes_shift_rows_pipe: MODE must be 0, 1 or 2");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("aes_shift_rows_pipe: TAG_W must be at least 1");
    end

    // Rows 2 and 3 shift one column further for the 256-bit block.
    function automatic int row_off(input int row);
        return (NB == 8 && row >= 2) ? row + 1 : row;
    endfunction

    logic [0:W-1] fwd_state;
    logic [0:W-1] inv_state;
    logic [0:W-1] perm_state;
    logic         dec_sel;

    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int FWD_SRC = 4 * ((c + row_off(r)) % NB) + r;
            localparam int INV_SRC = 4 * ((c + NB - row_off(r)) % NB) + r;
            assign fwd_state[8*(4*c+r) +: 8] = bus.in_state[8*FWD_SRC +: 8];
            assign inv_state[8*(4*c+r) +: 8] = bus.in_state[8*INV_SRC +: 8];
        end
    end

    assign dec_sel    = (MODE == 2) ? bus.in_dec : (MODE == 1);
    assign perm_state = dec_sel ? inv_state : fwd_state;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             pop;
    logic             out_valid;
    logic             load_main;
    logic             main_from_skid;
    logic             load_skid;

    logic [0:W-1]     main_state;
    logic [TAG_W-1:0] main_tag;
    logic [0:W-1]     skid_state;
    logic [TAG_W-1:0] skid_tag;

    // in_ready looks only at registered occupancy, never at out_ready, so no
    // combinational path runs from the downstream stage back upstream.
    assign bus.in_ready = !rst && !flush && (state != TWO);
    assign out_valid    = (state != EMPTY);
    assign accept       = bus.in_valid && bus.in_ready;
    assign pop          = out_valid && bus.out_ready;

    assign bus.out_valid = out_valid;
    assign bus.out_state = main_state;
    assign bus.out_tag   = main_tag;
    assign occupancy     = state;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;

        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (accept && pop) begin
                    load_main = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_nxt      = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase

        // Flush drops everything held, whether or not a pop was in progress.
        if (flush) begin
            state_nxt = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
    end

    // NOTE: state is registered with non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_state <= '0;
            main_tag   <= '0;
        end else if (load_main) begin
            main_state <= main_from_skid ? skid_state : perm_state;
            main_tag   <= main_from_skid ? skid_tag   : bus.in_tag;
        end
    end

    // NOTE: the skid entry is always written before it is read, so it carries
    // no reset and stays a plain enable flop bank.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_state <= perm_state;
            skid_tag   <= bus.in_tag;
        end
    end
endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Self-checking bench for aes_shift_rows_pipe: known vectors, backpressure, random
// FIFO stream against a queue model, flush/reset, and the NB=6/8 and fixed-inverse variants.
module tb_aes_shift_rows_pipe;
    localparam int TAG_W  = 4;
    localparam int BEATS  = 1000;
    localparam int BUDGET = 8000;

    typedef logic [0:255] wide_t;
    typedef struct packed {
        logic [0:127]     s;
        logic [TAG_W-1:0] t;
    } item_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [1:0] occ4, occ6, occ8, occi;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    aes_shift_rows_pipe_if #(.NB(4), .TAG_W(TAG_W)) bus4 ();
    aes_shift_rows_pipe_if #(.NB(6), .TAG_W(TAG_W)) bus6 ();
    aes_shift_rows_pipe_if #(.NB(8), .TAG_W(TAG_W)) bus8 ();
    aes_shift_rows_pipe_if #(.NB(4), .TAG_W(TAG_W)) busi ();

    aes_shift_rows_pipe #(.NB(4), .MODE(2), .TAG_W(TAG_W)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus4), .occupancy(occ4));
    aes_shift_rows_pipe #(.NB(6), .MODE(2), .TAG_W(TAG_W)) dut6 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus6), .occupancy(occ6));
    aes_shift_rows_pipe #(.NB(8), .MODE(2), .TAG_W(TAG_W)) dut8 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus8), .occupancy(occ8));
    aes_shift_rows_pipe #(.NB(4), .MODE(1), .TAG_W(TAG_W)) duti (
        .clk(clk), .rst(rst), .flush(flush), .bus(busi), .occupancy(occi));

    // Reference: out(r,c) = in(r,(c +/- C_r) mod nb), byte k = 4*col + row.
    function automatic wide_t ref_shift(input int nb, input wide_t s, input bit dec);
        int    offs4[4] = '{0, 1, 2, 3};
        int    offs8[4] = '{0, 1, 3, 4};
        wide_t r = '0;
        for (int c = 0; c < nb; c++) begin
            for (int row = 0; row < 4; row++) begin
                int off;
                int src;
                off = (nb == 8) ? offs8[row] : offs4[row];
                src = dec ? (c - off + nb) % nb : (c + off) % nb;
                r[8*(4*c+row) +: 8] = s[8*(4*src+row) +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [0:127] ref4(input logic [0:127] s, input bit dec);
        wide_t w;
        w = ref_shift(4, {s, 128'b0}, dec);
        return w[0:127];
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus4.in_valid  = 1'b1;
        bus4.in_state  = rand128();
        bus4.in_tag    = 4'hF;
        bus4.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus4.out_valid, occ4, bus4.out_tag} !== 7'b0 || bus4.out_state !== 128'b0) begin
            errors++;
            $display("FAIL reset_state got valid=%0b occ=%0d tag=%0h state=%h want all zero",
                     bus4.out_valid, occ4, bus4.out_tag, bus4.out_state);
        end
        checks++;
        if (bus4.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %0b want 0", bus4.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        bus4.in_valid = 1'b0;
        #1;
        checks++;
        if (bus4.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %0b want 1", bus4.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus4.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got out_valid=%0b want 0", bus4.out_valid);
        end
    endtask

    task automatic test_vectors();
        logic [0:127] seq, exp_fwd, exp_inv;
        for (int k = 0; k < 16; k++) seq[8*k +: 8] = 8'(k);
        exp_fwd = 128'h00050A0F04090E03080D02070C01060B;
        exp_inv = 128'h000D0A0704010E0B0805020F0C090603;

        @(negedge clk);
        bus4.out_ready = 1'b1;
        bus4.in_valid  = 1'b1;
        bus4.in_dec    = 1'b0;
        bus4.in_state  = seq;
        bus4.in_tag    = 4'h5;
        @(posedge clk); #1;
        checks++;
        if ({bus4.out_valid, bus4.out_state, bus4.out_tag} !== {1'b1, exp_fwd, 4'h5}) begin
            errors++;
            $display("FAIL vec_forward got v=%0b %h tag=%0h want v=1 %h tag=5",
                     bus4.out_valid, bus4.out_state, bus4.out_tag, exp_fwd);
        end

        @(negedge clk);
        bus4.in_dec = 1'b1;
        bus4.in_tag = 4'h6;
        @(posedge clk); #1;
        checks++;
        if ({bus4.out_valid, bus4.out_state, bus4.out_tag} !== {1'b1, exp_inv, 4'h6}) begin
            errors++;
            $display("FAIL vec_inverse got v=%0b %h tag=%0h want v=1 %h tag=6",
                     bus4.out_valid, bus4.out_state, bus4.out_tag, exp_inv);
        end

        @(negedge clk);
        bus4.in_state = exp_fwd;
        bus4.in_tag   = 4'h7;
        @(posedge clk); #1;
        checks++;
        if ({bus4.out_state, bus4.out_tag, occ4} !== {seq, 4'h7, 2'd1}) begin
            errors++;
            $display("FAIL vec_roundtrip got %h tag=%0h occ=%0d want %h tag=7 occ=1",
                     bus4.out_state, bus4.out_tag, occ4, seq);
        end

        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus4.out_valid, occ4} !== 3'b0) begin
            errors++;
            $display("FAIL vec_drain got v=%0b occ=%0d want 0 0", bus4.out_valid, occ4);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:127] s1, s2, s3;
        s1 = rand128(); s2 = rand128(); s3 = rand128();

        @(negedge clk);
        bus4.out_ready = 1'b0;
        bus4.in_valid  = 1'b1;
        bus4.in_dec    = 1'b0;
        bus4.in_state  = s1;
        bus4.in_tag    = 4'h1;
        @(posedge clk);
        @(negedge clk);
        bus4.in_dec   = 1'b1;
        bus4.in_state = s2;
        bus4.in_tag   = 4'h2;
        @(posedge clk);
        @(negedge clk);
        bus4.in_dec   = 1'b0;
        bus4.in_state = s3;
        bus4.in_tag   = 4'h3;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({occ4, bus4.in_ready, bus4.out_valid, bus4.out_state, bus4.out_tag} !==
                {2'd2, 1'b0, 1'b1, ref4(s1, 1'b0), 4'h1}) begin
                errors++;
                $display("FAIL bp_full[%0d] got occ=%0d rdy=%0b v=%0b %h tag=%0h want occ=2 rdy=0 v=1 %h tag=1",
                         i, occ4, bus4.in_ready, bus4.out_valid, bus4.out_state, bus4.out_tag, ref4(s1, 1'b0));
            end
            @(posedge clk);
            @(negedge clk);
        end

        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({occ4, bus4.out_state, bus4.out_tag} !== {2'd1, ref4(s2, 1'b1), 4'h2}) begin
            errors++;
            $display("FAIL bp_second got occ=%0d %h tag=%0h want occ=1 %h tag=2",
                     occ4, bus4.out_state, bus4.out_tag, ref4(s2, 1'b1));
        end
        @(posedge clk); #1;
        checks++;
        if ({occ4, bus4.out_state, bus4.out_tag} !== {2'd1, ref4(s3, 1'b0), 4'h3}) begin
            errors++;
            $display("FAIL bp_third got occ=%0d %h tag=%0h want occ=1 %h tag=3",
                     occ4, bus4.out_state, bus4.out_tag, ref4(s3, 1'b0));
        end
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus4.out_valid, occ4} !== 3'b0) begin
            errors++;
            $display("FAIL bp_drain got v=%0b occ=%0d want 0 0", bus4.out_valid, occ4);
        end
    endtask

    task automatic test_random_stream();
        item_t q[$];
        item_t it;
        int    sent = 0;
        int    got  = 0;
        int    cyc  = 0;
        bit    acc_prev = 1'b1;
        bit    acc, pop;

        while (got < BEATS && cyc < BUDGET) begin
            @(negedge clk);
            if (!bus4.in_valid || acc_prev) begin
                if (sent < BEATS && $urandom_range(0, 3) != 0) begin
                    bus4.in_valid = 1'b1;
                    bus4.in_dec   = sent[0];
                    bus4.in_state = rand128();
                    bus4.in_tag   = 4'($urandom);
                end else begin
                    bus4.in_valid = 1'b0;
                end
            end
            bus4.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            acc = bus4.in_valid && bus4.in_ready;
            pop = bus4.out_valid && bus4.out_ready;

            checks++;
            if ({bus4.out_valid, occ4} !== {q.size() != 0, 2'(q.size())}) begin
                errors++;
                $display("FAIL stream_occ cyc=%0d got v=%0b occ=%0d want v=%0b occ=%0d",
                         cyc, bus4.out_valid, occ4, q.size() != 0, q.size());
            end
            if (pop) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_pop_empty cyc=%0d got out_valid=1 want nothing queued", cyc);
                end else begin
                    it = q.pop_front();
                    if ({bus4.out_state, bus4.out_tag} !== {it.s, it.t}) begin
                        errors++;
                        $display("FAIL stream_data beat=%0d got %h tag=%0h want %h tag=%0h",
                                 got, bus4.out_state, bus4.out_tag, it.s, it.t);
                    end
                end
                got++;
            end
            if (acc) begin
                it.s = ref4(bus4.in_state, bus4.in_dec);
                it.t = bus4.in_tag;
                q.push_back(it);
                sent++;
            end
            acc_prev = acc;
            @(posedge clk);
            cyc++;
        end
        checks++;
        if (got < BEATS) begin
            errors++;
            $display("FAIL stream_timeout got %0d beats want %0d within %0d cycles", got, BEATS, BUDGET);
        end
        @(negedge clk);
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    // Fills the buffer to two entries, then applies rst (use_rst) or flush.
    task automatic test_clear(input bit use_rst);
        logic [0:127] s4;
        s4 = rand128();
        @(negedge clk);
        bus4.out_ready = 1'b0;
        bus4.in_valid  = 1'b1;
        bus4.in_dec    = 1'b0;
        bus4.in_state  = rand128();
        bus4.in_tag    = 4'hA;
        @(posedge clk);
        @(negedge clk);
        bus4.in_state = rand128();
        bus4.in_tag   = 4'hB;
        @(posedge clk);
        @(negedge clk);
        bus4.in_state = rand128();
        bus4.in_tag   = 4'hC;
        bus4.out_ready = 1'b1;
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        #1;
        checks++;
        if ({occ4, bus4.in_ready} !== {2'd2, 1'b0}) begin
            errors++;
            $display("FAIL clear_pre(rst=%0b) got occ=%0d rdy=%0b want occ=2 rdy=0", use_rst, occ4, bus4.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus4.out_valid, occ4, bus4.in_ready} !== 4'b0) begin
            errors++;
            $display("FAIL clear_post(rst=%0b) got v=%0b occ=%0d rdy=%0b want 0 0 0",
                     use_rst, bus4.out_valid, occ4, bus4.in_ready);
        end
        if (use_rst) begin
            checks++;
            if ({bus4.out_state, bus4.out_tag} !== 132'b0) begin
                errors++;
                $display("FAIL clear_rst_data got %h tag=%0h want zero", bus4.out_state, bus4.out_tag);
            end
        end
        @(negedge clk);
        rst   = 1'b0;
        flush = 1'b0;
        bus4.in_dec   = 1'b1;
        bus4.in_state = s4;
        bus4.in_tag   = 4'hD;
        @(posedge clk); #1;
        checks++;
        if ({bus4.out_valid, occ4, bus4.out_state, bus4.out_tag} !== {1'b1, 2'd1, ref4(s4, 1'b1), 4'hD}) begin
            errors++;
            $display("FAIL clear_resume(rst=%0b) got v=%0b occ=%0d %h tag=%0h want v=1 occ=1 %h tag=d",
                     use_rst, bus4.out_valid, occ4, bus4.out_state, bus4.out_tag, ref4(s4, 1'b1));
        end
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus4.out_valid, occ4} !== 3'b0) begin
            errors++;
            $display("FAIL clear_drain(rst=%0b) got v=%0b occ=%0d want 0 0", use_rst, bus4.out_valid, occ4);
        end
    endtask

    task automatic test_other_widths();
        wide_t        w, s8, f8, seq8;
        logic [0:191] s6, f6;
        logic [0:127] si, seq;
        for (int k = 0; k < 32; k++) seq8[8*k +: 8] = 8'(k);
        for (int k = 0; k < 16; k++) seq[8*k +: 8] = 8'(k);

        @(negedge clk);
        bus8.out_ready = 1'b1;
        bus6.out_ready = 1'b1;
        busi.out_ready = 1'b1;
        bus8.in_valid = 1'b1; bus8.in_dec = 1'b0; bus8.in_state = seq8; bus8.in_tag = 4'h3;
        busi.in_valid = 1'b1; busi.in_dec = 1'b0; busi.in_state = seq;  busi.in_tag = 4'h9;
        @(posedge clk); #1;
        checks++;
        if (bus8.out_state[0:31] !== 32'h00050E13) begin
            errors++;
            $display("FAIL nb8_col0 got %h want 00050e13", bus8.out_state[0:31]);
        end
        w = ref_shift(8, seq8, 1'b0);
        checks++;
        if ({bus8.out_valid, bus8.out_state, bus8.out_tag} !== {1'b1, w, 4'h3}) begin
            errors++;
            $display("FAIL nb8_seq got v=%0b %h want v=1 %h", bus8.out_valid, bus8.out_state, w);
        end
        checks++;
        if ({busi.out_state, busi.out_tag} !== {128'h000D0A0704010E0B0805020F0C090603, 4'h9}) begin
            errors++;
            $display("FAIL mode1_fixed_inverse got %h tag=%0h want 000d0a0704010e0b0805020f0c090603 tag=9",
                     busi.out_state, busi.out_tag);
        end

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s6 = {rand128(), $urandom, $urandom};
            s8 = {rand128(), rand128()};
            si = rand128();
            bus6.in_valid = 1'b1; bus6.in_dec = 1'b0; bus6.in_state = s6; bus6.in_tag = 4'(i);
            bus8.in_dec = 1'b0; bus8.in_state = s8; bus8.in_tag = 4'(i + 1);
            busi.in_dec = 1'($urandom_range(0, 1)); busi.in_state = si; busi.in_tag = 4'(i + 2);
            @(posedge clk); #1;
            w  = ref_shift(6, {s6, 64'b0}, 1'b0);
            f6 = w[0:191];
            f8 = ref_shift(8, s8, 1'b0);
            w  = ref_shift(4, {si, 128'b0}, 1'b1);
            checks++;
            if ({bus6.out_valid, bus6.out_state, bus6.out_tag} !== {1'b1, f6, 4'(i)}) begin
                errors++;
                $display("FAIL nb6_fwd[%0d] got %h want %h", i, bus6.out_state, f6);
            end
            checks++;
            if ({bus8.out_valid, bus8.out_state, bus8.out_tag} !== {1'b1, f8, 4'(i + 1)}) begin
                errors++;
                $display("FAIL nb8_fwd[%0d] got %h want %h", i, bus8.out_state, f8);
            end
            checks++;
            if ({busi.out_state, busi.out_tag} !== {w[0:127], 4'(i + 2)}) begin
                errors++;
                $display("FAIL mode1_rand[%0d] got %h want %h", i, busi.out_state, w[0:127]);
            end
            @(negedge clk);
            bus6.in_dec = 1'b1; bus6.in_state = f6;
            bus8.in_dec = 1'b1; bus8.in_state = f8;
            @(posedge clk); #1;
            checks++;
            if (bus6.out_state !== s6) begin
                errors++;
                $display("FAIL nb6_roundtrip[%0d] got %h want %h", i, bus6.out_state, s6);
            end
            checks++;
            if (bus8.out_state !== s8) begin
                errors++;
                $display("FAIL nb8_roundtrip[%0d] got %h want %h", i, bus8.out_state, s8);
            end
        end
        @(negedge clk);
        bus6.in_valid = 1'b0;
        bus8.in_valid = 1'b0;
        busi.in_valid = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_dec = 1'b0; bus4.in_state = '0; bus4.in_tag = '0; bus4.out_ready = 1'b0;
        bus6.in_valid = 1'b0; bus6.in_dec = 1'b0; bus6.in_state = '0; bus6.in_tag = '0; bus6.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.in_dec = 1'b0; bus8.in_state = '0; bus8.in_tag = '0; bus8.out_ready = 1'b0;
        busi.in_valid = 1'b0; busi.in_dec = 1'b0; busi.in_state = '0; busi.in_tag = '0; busi.out_ready = 1'b0;

        test_reset();
        test_vectors();
        test_back_to_back();
        test_random_stream();
        test_clear(1'b0);
        test_clear(1'b1);
        test_other_widths();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no completion want summary before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
